cmp_share_arb: RTL and testbench
================================

# cmp_share_arb

Round-robin arbiter and two-stage sequencer that shares one 4-bit compare datapath among several requesters. The datapath computes inequality (OR-reduced XOR) and unsigned less-than (carry-out of a + ~b + 1). Each requester presents an operand pair and receives a held result. The block sits between requester logic and the single comparator instance, so the comparator is never duplicated per requester.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, operand width in bits

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  requester i has an operand pair
- req_a  in  NREQ*WIDTH  operand A; slice i is [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B; same slicing as req_a
- req_ready  out  NREQ  one-hot or zero; grant/accept this cycle
- rsp_valid  out  NREQ  result held for requester i
- rsp_ready  in  NREQ  requester i consumes its result
- rsp_ne  out  NREQ  bit i = (a != b) for requester i's last accepted pair
- rsp_lt  out  NREQ  bit i = unsigned (a < b)

## Operation
- Eligible(i) = req_valid[i] & ~pend[i]. pend[i] is set on accept and cleared when the rsp_valid[i] & rsp_ready[i] handshake completes.
- Arbitration is combinational from req_valid and state:
  - req_ready[i] = 1 only for the single winner among eligible requesters.
  - An accept is req_valid[i] & req_ready[i].
  - req_ready never asserts for a non-eligible requester.
- Stage 1 (S1) captures the winner's operands and index into s1_a, s1_b, s1_idx, with s1_vld set on accept.
- Stage 2 (S2):
  - The comparator evaluates s1_a / s1_b.
  - ne = |(a ^ b).
  - lt = ~carry_out(a + ~b + 1), computed WIDTH bits wide with no sign extension.
  - Results are written into rsp_ne[s1_idx] and rsp_lt[s1_idx], and rsp_valid[s1_idx] is set.
- rsp_ne / rsp_lt bits stay stable while rsp_valid[i] is high. They keep their last value after consumption.
- The datapath is fully pipelined: one accept per cycle. At most one outstanding operation exists per requester.
- Requester i re-asserting valid in the same cycle its response handshakes is not eligible that cycle, because pend clears at the edge.
- Reset values:
  - req_ready = 0 while rst is high.
  - rsp_valid = 0, rsp_ne = 0, rsp_lt = 0.
  - pend = 0, s1_vld = 0, RR pointer = 0.
- Reset mid-operation drops any in-flight S1 entry and all held results. The first accept after rst deasserts is arbitrated from pointer 0.

## Timing
- Cycle N: accept for requester i.
- Edge end of N: S1 loaded.
- Edge end of N+1: result written.
- rsp_valid[i] = 1 from cycle N+2. Accept-to-result latency is 2 cycles.
- rsp_valid[i] drops on the edge after the cycle with rsp_ready[i] = 1.
- rsp_ready[i] while rsp_valid[i] = 0 is ignored.
- Back-to-back accepts of different requesters in N and N+1 give results in N+2 and N+3.
- There is no stall path. S2 write targets are always free because pend blocks a second issue.

## Configuration
- CMP_SHARE_ARB_RR_EN defined:
  - Round-robin arbitration.
  - Search starts at the pointer and wraps modulo NREQ.
  - On accept, pointer <= winner+1, wrapping NREQ-1 -> 0.
  - Pointer is unchanged with no accept.
- Undefined:
  - Fixed priority; the lowest eligible index wins.
  - No pointer register.
- Ports and latency are identical in both builds.

## Test plan
- Single request, req0 a=4'h5 b=4'h5 -> req_ready[0]=1 in N; rsp_valid[0]=1 at N+2 with ne=0, lt=0; held until rsp_ready[0].
- Unsigned compare, req1 a=4'h3 b=4'hC -> ne=1, lt=1. req1 a=4'hF b=4'h0 -> ne=1, lt=0. Confirms no signed interpretation.
- All four valid continuously, rsp_ready tied 1:
  - RR build grants 0,1,2,3,0,...
  - Fixed build: requester 0 is granted only every third cycle (N, N+3, ...) while its pend blocks it, and requesters 1, 2 fill the gaps. Requester 3 is never granted.
- Backpressure, req2 with rsp_ready[2]=0 for 10 cycles -> req_ready[2] stays 0 despite req_valid[2]=1; rsp_ne/lt[2] stable. Other requesters are still served each cycle.
- Reset mid-flight: assert rst one cycle after an accept -> no rsp_valid ever appears for it, all outputs are 0, and the next grant comes from pointer 0 (RR build).

Source files
------------

// File: rtl/cmp_share_arb.sv
// cmp_share_arb: arbitrates NREQ requesters onto one shared compare datapath (ne / unsigned lt).
// Define CMP_SHARE_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.

module cmp_share_arb_cmp #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ne,
   output logic             lt
);
   logic [WIDTH:0] sum;

   // a + ~b + 1 with no carry out means a borrowed, i.e. a < b unsigned
   assign sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign ne  = |(a ^ b);
   assign lt  = ~sum[WIDTH];
endmodule

module cmp_share_arb #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [NREQ-1:0]       rsp_ne,
   output logic [NREQ-1:0]       rsp_lt
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]  pend_q, pend_d;
   logic             s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [IW-1:0]    s1_idx_q, s1_idx_d;
   logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [NREQ-1:0]  rsp_ne_q, rsp_ne_d;
   logic [NREQ-1:0]  rsp_lt_q, rsp_lt_d;

   logic [NREQ-1:0]  elig;
   logic             win_vld;
   logic [IW-1:0]    win_idx;
   logic             accept;
   logic             cmp_ne, cmp_lt;
   logic [WIDTH-1:0] op_a [NREQ];
   logic [WIDTH-1:0] op_b [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_ops
      assign op_a[g] = req_a[g*WIDTH +: WIDTH];
      assign op_b[g] = req_b[g*WIDTH +: WIDTH];
   end

   assign elig = req_valid & ~pend_q;

`ifdef CMP_SHARE_ARB_RR_EN
   logic [IW-1:0] ptr_q, ptr_d;
   int            cand;

   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!win_vld && elig[IW'(cand)]) begin
            win_vld = 1'b1;
            win_idx = IW'(cand);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept) ptr_d = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`else
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (elig[k]) begin
            win_vld = 1'b1;
            win_idx = IW'(k);
         end
      end
   end
`endif

   always_comb begin
      req_ready = '0;
      if (win_vld && !rst) req_ready[win_idx] = 1'b1;
   end

   assign accept = |(req_valid & req_ready);

   cmp_share_arb_cmp #(.WIDTH(WIDTH)) u_cmp (
      .a  (s1_a_q),
      .b  (s1_b_q),
      .ne (cmp_ne),
      .lt (cmp_lt)
   );

   always_comb begin
      pend_d   = (pend_q | (req_valid & req_ready)) & ~(rsp_valid_q & rsp_ready);
      s1_vld_d = accept;
      s1_a_d   = s1_a_q;
      s1_b_d   = s1_b_q;
      s1_idx_d = s1_idx_q;
      if (accept) begin
         s1_a_d   = op_a[win_idx];
         s1_b_d   = op_b[win_idx];
         s1_idx_d = win_idx;
      end
      rsp_valid_d = rsp_valid_q & ~rsp_ready;
      rsp_ne_d    = rsp_ne_q;
      rsp_lt_d    = rsp_lt_q;
      // pend guarantees the target slot is free, so S2 never collides with a handshake
      if (s1_vld_q) begin
         rsp_valid_d[s1_idx_q] = 1'b1;
         rsp_ne_d[s1_idx_q]    = cmp_ne;
         rsp_lt_d[s1_idx_q]    = cmp_lt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q      <= '0;
         s1_vld_q    <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_idx_q    <= '0;
         rsp_valid_q <= '0;
         rsp_ne_q    <= '0;
         rsp_lt_q    <= '0;
      end else begin
         pend_q      <= pend_d;
         s1_vld_q    <= s1_vld_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_idx_q    <= s1_idx_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_ne_q    <= rsp_ne_d;
         rsp_lt_q    <= rsp_lt_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_ne    = rsp_ne_q;
   assign rsp_lt    = rsp_lt_q;
endmodule

// File: tb/tb_cmp_share_arb.sv
// Bench for cmp_share_arb: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a transaction-level model of arbitration and results.
module tb_cmp_share_arb;
   localparam int NREQ  = 4;
   localparam int WIDTH = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a, req_b;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [NREQ-1:0]       rsp_ne, rsp_lt;

   cmp_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_ne    (rsp_ne),
      .rsp_lt    (rsp_lt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: per-requester pending flag, cycles left until the result lands, held result.
   bit m_pend [NREQ];
   bit m_rv   [NREQ];
   bit m_ne   [NREQ];
   bit m_lt   [NREQ];
   int m_cnt  [NREQ];
   bit m_pne  [NREQ];
   bit m_plt  [NREQ];
   int m_ptr;

   typedef struct {
      int         id;
      logic [3:0] a;
      logic [3:0] b;
      logic       ne;
      logic       lt;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_winner();
      for (int k = 0; k < NREQ; k++) begin
         int j;
`ifdef CMP_SHARE_ARB_RR_EN
         j = (m_ptr + k) % NREQ;
`else
         j = k;
`endif
         if (req_valid[j] && !m_pend[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_check();
      logic [NREQ-1:0] er, ev, en, el;
      int w;
      w  = m_winner();
      er = '0;
      if (!rst && w >= 0) er[w] = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         ev[i] = m_rv[i];
         en[i] = m_ne[i];
         el[i] = m_lt[i];
      end
      chk("model_req_ready", 32'(req_ready), 32'(er));
      chk("model_rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("model_rsp_ne",    32'(rsp_ne),    32'(en));
      chk("model_rsp_lt",    32'(rsp_lt),    32'(el));
   endtask

   task automatic model_update();
      int w, a, b;
      w = m_winner();
      if (rst) begin
         for (int i = 0; i < NREQ; i++) begin
            m_pend[i] = 0; m_rv[i] = 0; m_ne[i] = 0; m_lt[i] = 0; m_cnt[i] = 0;
         end
         m_ptr = 0;
      end else begin
         for (int i = 0; i < NREQ; i++)
            if (m_rv[i] && rsp_ready[i]) begin
               m_rv[i]   = 0;
               m_pend[i] = 0;
            end
         for (int i = 0; i < NREQ; i++)
            if (m_cnt[i] > 0) begin
               m_cnt[i]--;
               if (m_cnt[i] == 0) begin
                  m_rv[i] = 1;
                  m_ne[i] = m_pne[i];
                  m_lt[i] = m_plt[i];
               end
            end
         if (w >= 0) begin
            a = int'(req_a[w*WIDTH +: WIDTH]);
            b = int'(req_b[w*WIDTH +: WIDTH]);
            m_pne[w]  = (a != b);
            m_plt[w]  = (a < b);
            m_pend[w] = 1;
            m_cnt[w]  = 1;
            m_ptr     = (w + 1) % NREQ;
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic rand_ops();
      req_a = NREQ*WIDTH'($urandom);
      req_b = NREQ*WIDTH'($urandom);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '1;
      rsp_ready = '0;
      rand_ops();
      @(posedge clk); model_update(); #1;
      @(posedge clk); model_update(); #1;
      sample();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_ne",    32'(rsp_ne),    32'd0);
      chk("rst_rsp_lt",    32'(rsp_lt),    32'd0);
      advance();
      rst       = 1'b0;
      req_valid = '0;
   endtask

   task automatic run_vec(input vec_t v);
      req_valid       = '0;
      rsp_ready       = '0;
      req_valid[v.id] = 1'b1;
      req_a[v.id*WIDTH +: WIDTH] = v.a;
      req_b[v.id*WIDTH +: WIDTH] = v.b;
      sample();
      chk("vec_grant", 32'(req_ready), 32'(1 << v.id));
      advance();
      req_valid = '0;
      sample();
      chk("vec_not_yet", 32'(rsp_valid[v.id]), 32'd0);
      advance();
      sample();
      chk("vec_valid", 32'(rsp_valid[v.id]), 32'd1);
      chk("vec_ne",    32'(rsp_ne[v.id]),    32'(v.ne));
      chk("vec_lt",    32'(rsp_lt[v.id]),    32'(v.lt));
      advance();
      rsp_ready[v.id] = 1'b1;
      sample();
      chk("vec_hold_valid", 32'(rsp_valid[v.id]), 32'd1);
      chk("vec_hold_ne",    32'(rsp_ne[v.id]),    32'(v.ne));
      chk("vec_hold_lt",    32'(rsp_lt[v.id]),    32'(v.lt));
      advance();
      rsp_ready = '0;
      sample();
      chk("vec_consumed", 32'(rsp_valid[v.id]), 32'd0);
      chk("vec_keep_ne",  32'(rsp_ne[v.id]),    32'(v.ne));
      chk("vec_keep_lt",  32'(rsp_lt[v.id]),    32'(v.lt));
      advance();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ-1:0] exp_rdy;
      vecs[0] = '{0, 4'h5, 4'h5, 1'b0, 1'b0};
      vecs[1] = '{1, 4'h3, 4'hC, 1'b1, 1'b1};
      vecs[2] = '{1, 4'hF, 4'h0, 1'b1, 1'b0};
      vecs[3] = '{2, 4'h0, 4'hF, 1'b1, 1'b1};
      vecs[4] = '{3, 4'h8, 4'h7, 1'b1, 1'b0};
      vecs[5] = '{3, 4'h7, 4'h8, 1'b1, 1'b1};
      vecs[6] = '{2, 4'hF, 4'hF, 1'b0, 1'b0};
      vecs[7] = '{0, 4'h0, 4'h1, 1'b1, 1'b1};
      req_a = '0;
      req_b = '0;

      do_reset();
      for (int v = 0; v < 8; v++) run_vec(vecs[v]);

      // All requesters valid, responses always consumed
      do_reset();
      req_valid = '1;
      rsp_ready = '1;
      for (int c = 0; c < 12; c++) begin
         rand_ops();
         exp_rdy = '0;
`ifdef CMP_SHARE_ARB_RR_EN
         exp_rdy[c % 4] = 1'b1;
`else
         exp_rdy[c % 3] = 1'b1;
`endif
         sample();
         chk("seq_grant", 32'(req_ready), 32'(exp_rdy));
         advance();
      end
      req_valid = '0;
      repeat (4) begin sample(); advance(); end

      // Backpressure on requester 2
      do_reset();
      rsp_ready = 4'b1011;
      req_valid = 4'b0100;
      req_a[2*WIDTH +: WIDTH] = 4'h9;
      req_b[2*WIDTH +: WIDTH] = 4'h2;
      repeat (3) begin sample(); advance(); end
      req_valid = '1;
      for (int c = 0; c < 10; c++) begin
         rand_ops();
         sample();
         chk("bp_ready2",  32'(req_ready[2]), 32'd0);
         chk("bp_valid2",  32'(rsp_valid[2]), 32'd1);
         chk("bp_ne2",     32'(rsp_ne[2]),    32'd1);
         chk("bp_lt2",     32'(rsp_lt[2]),    32'd0);
         chk("bp_others",  32'(|req_ready),   32'd1);
         advance();
      end
      req_valid = '0;
      rsp_ready = '1;
      repeat (4) begin sample(); advance(); end

      // Reset one cycle after an accept
      do_reset();
      req_valid = 4'b0010;
      req_a[1*WIDTH +: WIDTH] = 4'h1;
      req_b[1*WIDTH +: WIDTH] = 4'h6;
      sample();
      chk("mid_grant", 32'(req_ready), 32'h2);
      advance();
      rst       = 1'b1;
      req_valid = '0;
      sample();
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      advance();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         sample();
         chk("mid_no_valid", 32'(rsp_valid), 32'd0);
         chk("mid_ne_zero",  32'(rsp_ne),    32'd0);
         chk("mid_lt_zero",  32'(rsp_lt),    32'd0);
         advance();
      end
      req_valid = '1;
      sample();
      chk("mid_next_grant", 32'(req_ready), 32'h1);
      advance();
      req_valid = '0;
      rsp_ready = '1;
      repeat (4) begin sample(); advance(); end

      // Randomized traffic with occasional reset
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom_range(0, 60) == 0);
         req_valid = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
         rand_ops();
         sample();
         advance();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
